// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter sequencing one 8-bit RAM access per grant, with locked bursts
// Ports: clk, reset (sync, active-high); per port pX_req/we/lock/addr/wdata in, pX_gnt/pX_done out;
//   rdata out (valid with pX_done of a read); mem_addr/mem_wdata/mem_we/mem_re out, mem_rdata in.
// Define ARB_FIXED_PRIO_EN to make port 0 always win ties instead of round-robin.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic       p0_lock,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  output logic       p0_gnt,
  output logic       p0_done,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic       p1_lock,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  output logic       p1_gnt,
  output logic       p1_done,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic win, own_req, own_lock, cont, load;
`ifdef ARB_FIXED_PRIO_EN
  assign win = !p0_req;
`else
  assign win = (p0_req && p1_req) ? !last_q : p1_req;
`endif
  always_comb begin
    own_req  = owner_q ? p1_req : p0_req;
    own_lock = owner_q ? p1_lock : p0_lock;
    cont     = state_q == DONE && own_req && own_lock && burst_q < BW'(MAX_BURST - 1);
    load     = (state_q == IDLE && (p0_req || p1_req)) || cont;
    owner_d  = state_q == IDLE ? win : owner_q;
    state_d  = load ? ISSUE : state_q == ISSUE ? DONE : IDLE;
    last_d   = state_q == ISSUE ? owner_q : last_q;
    burst_d  = cont ? burst_q + 1'b1 : state_q == DONE ? '0 : burst_q;
    we_d     = load ? (owner_d ? p1_we : p0_we) : we_q;
    addr_d   = load ? (owner_d ? p1_addr : p0_addr) : addr_q;
    wdata_d  = load ? (owner_d ? p1_wdata : p0_wdata) : wdata_q;
    rdata_d  = (state_q == DONE && !we_q) ? mem_rdata : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      burst_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign p0_gnt    = state_q == ISSUE && !owner_q;
  assign p1_gnt    = state_q == ISSUE && owner_q;
  assign p0_done   = state_q == DONE && !owner_q;
  assign p1_done   = state_q == DONE && owner_q;
  assign mem_we    = state_q == ISSUE && we_q;
  assign mem_re    = state_q == ISSUE && !we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_d;
endmodule
